// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   INST_ADDR_W / INST_W : instruction address and word widths
//   RESET_PC_DEFAULT     : default first fetch address
//   fetch_entry_t        : {pc, inst} payload buffered towards decode
//   align_pc()           : forces a fetch address onto a word boundary
package ifu_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] INST_STEP        = 32'd4;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Clear the byte-offset bits of a fetch address.
    function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] pc);
        return pc & ~INST_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with registered storage; head entry read straight from storage.
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : drop all entries (wins over push_i)
//   push_i, data_i  : write one entry
//   pop_i, data_o   : data_o is the head entry, removed on pop_i
//   count_o, full_o, empty_o : occupancy status
module ifu_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              data_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer/occupancy next state; a pop frees the slot a same-cycle push needs.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push & ~do_pop)      count_d = count_q + CNT_W'(1);
            else if (~do_push & do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push & ~clear_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: drives iram fetch address/read enable, captures the
// one-cycle-latency instruction word and presents {pc,inst} to decode via valid/ready.
//   clk, rst                      : clock, synchronous active-high reset
//   redirect_i, redirect_pc_i     : flush and restart fetch at an aligned target
//   iram_busy_i                   : iram in its reset window, fetch parked at RESET_PC
//   pc_n_o, iram_rd_o             : iram fetch address / read enable (combinational)
//   iram_inst_i                   : iram word, valid the cycle after iram_rd_o
//   id_valid_o, id_ready_i        : decode handshake
//   id_pc_o, id_inst_o            : presented instruction
// Optional: IFU_PERF_CNT_EN adds perf_fetch_o (pushes) and perf_stall_o (stalled cycles).
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        iram_busy_i,
    output logic [31:0] pc_n_o,
    output logic        iram_rd_o,
    input  logic [31:0] iram_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             issue, push, pop, credit_ok;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             unused_fifo_full;
    fetch_entry_t     push_entry, head_entry;

    // Credit counts buffered plus in-flight words; a pop this cycle returns one credit.
    always_comb begin
        pc_n_o        = redirect_i ? align_pc(redirect_pc_i) : fetch_pc_q;
        pop           = ~fifo_empty & id_ready_i;
        credit_ok     = (OCC_W'(fifo_count) + OCC_W'(inflight_q))
                        < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
        issue         = ~rst & ~iram_busy_i & (credit_ok | redirect_i);
        push          = inflight_q & ~redirect_i & ~iram_busy_i;
        push_entry    = '{pc: inflight_pc_q, inst: iram_inst_i};
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_n_o;
            fetch_pc_d    = pc_n_o + INST_STEP;
        end else if (iram_busy_i) begin
            fetch_pc_d    = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Redirect clears the buffer; the credit scheme keeps pushes off a full FIFO.
    ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (unused_fifo_full),
        .empty_o (fifo_empty)
    );

    assign iram_rd_o  = issue;
    assign id_valid_o = ~fifo_empty;
    assign id_pc_o    = head_entry.pc;
    assign id_inst_o  = head_entry.inst;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running event counters, wrapping at 2^32.
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(push);
        perf_stall_d = perf_stall_q + 32'(id_valid_o & ~id_ready_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: streaming, decode backpressure, redirects (incl. wrap),
// iram busy window and, when IFU_PERF_CNT_EN is defined, the perf counters.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        iram_busy_i;
    logic [31:0] pc_n_o;
    logic        iram_rd_o;
    logic [31:0] iram_inst_i = 32'h0;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .iram_busy_i   (iram_busy_i),
        .pc_n_o        (pc_n_o),
        .iram_rd_o     (iram_rd_o),
        .iram_inst_i   (iram_inst_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    // Memory contents: each word is its address XOR a fixed pattern.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // iram model: one-cycle read latency.
    always @(posedge clk) begin
        if (iram_rd_o) iram_inst_i <= word_at(pc_n_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(id_valid_o), 32'd1);
        chk({tag, "_pc"}, id_pc_o, pc);
        chk({tag, "_inst"}, id_inst_o, word_at(pc));
    endtask

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        iram_busy_i = 1'b0; id_ready_i = 1'b1;
        cyc(); cyc();
        #1;
        // Reset state
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_rd", 32'(iram_rd_o), 32'd0);
        chk("rst_pc_n", pc_n_o, 32'h0);
        chk("rst_id_pc", id_pc_o, 32'h0);
        chk("rst_id_inst", id_inst_o, 32'h0);

        // Test 1: streaming fetch after reset release (cycle 0 .. 7)
        rst = 1'b0;
        #1;
        chk("t1_c0_rd", 32'(iram_rd_o), 32'd1);
        chk("t1_c0_pc_n", pc_n_o, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            cyc(); #1;
            chk("t1_pc_n", pc_n_o, 32'(4 * k));
            chk("t1_rd", 32'(iram_rd_o), 32'd1);
            if (k == 1) chk("t1_c1_valid", 32'(id_valid_o), 32'd0);
            else        chk_head("t1_head", 32'(4 * (k - 2)));
        end

        // Test 2: decode stalls for 10 cycles (cycles 8..17)
        cyc(); id_ready_i = 1'b0; #1;
        chk("t2_c8_rd", 32'(iram_rd_o), 32'd0);
        chk("t2_c8_pc_n", pc_n_o, 32'd32);
        chk_head("t2_c8", 32'd24);
        for (int k = 9; k <= 17; k++) begin
            cyc(); #1;
            chk("t2_hold_rd", 32'(iram_rd_o), 32'd0);
            chk_head("t2_hold", 32'd24);
        end
        cyc(); id_ready_i = 1'b1; #1;
        chk("t2_c18_rd", 32'(iram_rd_o), 32'd1);
        chk_head("t2_c18", 32'd24);
        for (int j = 1; j <= 3; j++) begin
            cyc(); #1;
            chk_head("t2_resume", 32'(24 + 4 * j));
        end

        // Test 3: redirect to 0x103 while FIFO full (cycles 22..27)
        cyc(); id_ready_i = 1'b0; #1;
        chk_head("t3_c22", 32'd40);
        cyc(); #1;
        chk_head("t3_c23", 32'd40);
        chk("t3_full_rd", 32'(iram_rd_o), 32'd0);
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; #1;
        chk("t3_redir_pc_n", pc_n_o, 32'h0000_0100);
        chk("t3_redir_rd", 32'(iram_rd_o), 32'd1);
        cyc(); redirect_i = 1'b0; id_ready_i = 1'b1; #1;
        chk("t3_flush_valid", 32'(id_valid_o), 32'd0);
        chk("t3_flush_pc_n", pc_n_o, 32'h0000_0104);
        cyc(); #1;
        chk_head("t3_tgt0", 32'h0000_0100);
        cyc(); #1;
        chk_head("t3_tgt1", 32'h0000_0104);

        // Test 5: redirect to the top word, fetch wraps to 0 (cycles 28..31)
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
        chk("t5_redir_pc_n", pc_n_o, 32'hFFFF_FFFC);
        chk_head("t5_c28", 32'h0000_0108);
        cyc(); redirect_i = 1'b0; #1;
        chk("t5_flush_valid", 32'(id_valid_o), 32'd0);
        chk("t5_wrap_pc_n", pc_n_o, 32'h0000_0000);
        cyc(); #1;
        chk_head("t5_top", 32'hFFFF_FFFC);
        cyc(); #1;
        chk_head("t5_wrap", 32'h0000_0000);

        // Test 4 (+6): reset, iram busy for 3 cycles, then fetch with backpressure
        cyc(); rst = 1'b1; iram_busy_i = 1'b1; id_ready_i = 1'b0;
        cyc();
        rst = 1'b0; #1;
        chk("t4_rst_valid", 32'(id_valid_o), 32'd0);
        chk("t4_rst_id_pc", id_pc_o, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("t6_rst_fetch", perf_fetch_o, 32'd0);
        chk("t6_rst_stall", perf_stall_o, 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            chk("t4_busy_rd", 32'(iram_rd_o), 32'd0);
            chk("t4_busy_pc_n", pc_n_o, 32'h0);
            chk("t4_busy_valid", 32'(id_valid_o), 32'd0);
            cyc();
        end
        iram_busy_i = 1'b0; #1;
        chk("t4_b0_rd", 32'(iram_rd_o), 32'd1);
        chk("t4_b0_pc_n", pc_n_o, 32'h0);
        cyc(); #1;
        chk("t4_b1_pc_n", pc_n_o, 32'd4);
        chk("t4_b1_valid", 32'(id_valid_o), 32'd0);
        cyc(); #1;
        chk_head("t4_first", 32'h0);
        chk("t4_b2_rd", 32'(iram_rd_o), 32'd0);
        cyc(); #1;
        chk_head("t4_b3", 32'h0);
        chk("t4_b3_rd", 32'(iram_rd_o), 32'd0);
        cyc(); #1;
        chk_head("t4_b4", 32'h0);
        cyc(); id_ready_i = 1'b1; #1;
        chk_head("t4_b5", 32'h0);
        chk("t4_b5_pc_n", pc_n_o, 32'd8);
        for (int j = 1; j <= 3; j++) begin
            cyc(); #1;
            chk_head("t4_stream", 32'(4 * j));
        end
        cyc(); #1;
        chk_head("t4_b9", 32'd16);
`ifdef IFU_PERF_CNT_EN
        chk("t6_fetch", perf_fetch_o, 32'd5);
        chk("t6_stall", perf_stall_o, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
